// File: rtl/id_stage_fwd.sv
// Decode-stage back end: operand forwarding, branch/jr resolution in ID, hazard detection
// (load-use, branch-operand), ID/EX pipeline register and a saturating stall counter.
module id_stage_fwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              freeze_i,
    // ID stage
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_pc_4_i,
    input  logic [AW-1:0]     id_rs_addr_i,
    input  logic [AW-1:0]     id_rt_addr_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [DATA_W-1:0] id_rs_rf_i,
    input  logic [DATA_W-1:0] id_rt_rf_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_beq_i,
    input  logic              id_bne_i,
    input  logic              id_jr_i,
    input  logic              id_wr_en_i,
    input  logic              id_is_load_i,
    input  logic [AW-1:0]     id_wr_addr_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    // EX / MEM / WB producers
    input  logic [DATA_W-1:0] ex_alu_result_i,
    input  logic              mem_wr_en_i,
    input  logic              mem_is_load_i,
    input  logic [AW-1:0]     mem_wr_addr_i,
    input  logic [DATA_W-1:0] mem_wr_data_i,
    input  logic              wb_wr_en_i,
    input  logic [AW-1:0]     wb_wr_addr_i,
    input  logic [DATA_W-1:0] wb_wr_data_i,
    // Hazard and redirect
    output logic              stall_o,
    output logic              br_taken_o,
    output logic [DATA_W-1:0] br_target_o,
    // ID/EX register
    output logic              ex_valid_o,
    output logic              ex_wr_en_o,
    output logic              ex_is_load_o,
    output logic [AW-1:0]     ex_wr_addr_o,
    output logic [DATA_W-1:0] ex_rs_val_o,
    output logic [DATA_W-1:0] ex_rt_val_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    logic              ex_valid_q, ex_valid_d;
    logic              ex_wr_en_q, ex_wr_en_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [AW-1:0]     ex_wr_addr_q, ex_wr_addr_d;
    logic [DATA_W-1:0] ex_rs_val_q, ex_rs_val_d;
    logic [DATA_W-1:0] ex_rt_val_q, ex_rt_val_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rs_live, rt_live;
    logic              ex_hit_rs, ex_hit_rt;
    logic              mem_hit_rs, mem_hit_rt;
    logic              wb_hit_rs, wb_hit_rt;
    logic [DATA_W-1:0] br_rs, br_rt;
    logic [DATA_W-1:0] op_rs, op_rt;
    logic              is_branch;
    logic              ops_eq;
    logic              stall;

    // A source only participates in matching when it is actually read and is not r0.
    assign rs_live = id_use_rs_i && (id_rs_addr_i != '0);
    assign rt_live = id_use_rt_i && (id_rt_addr_i != '0);

    assign ex_hit_rs  = rs_live && ex_valid_q && ex_wr_en_q && (ex_wr_addr_q == id_rs_addr_i);
    assign ex_hit_rt  = rt_live && ex_valid_q && ex_wr_en_q && (ex_wr_addr_q == id_rt_addr_i);
    assign mem_hit_rs = rs_live && mem_wr_en_i && (mem_wr_addr_i == id_rs_addr_i);
    assign mem_hit_rt = rt_live && mem_wr_en_i && (mem_wr_addr_i == id_rt_addr_i);
    assign wb_hit_rs  = rs_live && wb_wr_en_i && (wb_wr_addr_i == id_rs_addr_i);
    assign wb_hit_rt  = rt_live && wb_wr_en_i && (wb_wr_addr_i == id_rt_addr_i);

    // Branch operands stop at MEM; EX results arrive too late for the ID compare.
    always_comb begin
        br_rs = id_rs_rf_i;
        if (wb_hit_rs) begin
            br_rs = wb_wr_data_i;
        end
        if (mem_hit_rs && !mem_is_load_i) begin
            br_rs = mem_wr_data_i;
        end
        if (id_rs_addr_i == '0) begin
            br_rs = '0;
        end

        br_rt = id_rt_rf_i;
        if (wb_hit_rt) begin
            br_rt = wb_wr_data_i;
        end
        if (mem_hit_rt && !mem_is_load_i) begin
            br_rt = mem_wr_data_i;
        end
        if (id_rt_addr_i == '0) begin
            br_rt = '0;
        end
    end

    always_comb begin
        op_rs = br_rs;
        if (ex_hit_rs && !ex_is_load_q) begin
            op_rs = ex_alu_result_i;
        end
        op_rt = br_rt;
        if (ex_hit_rt && !ex_is_load_q) begin
            op_rt = ex_alu_result_i;
        end
    end

    assign is_branch = id_beq_i || id_bne_i || id_jr_i;
    assign ops_eq    = (br_rs == br_rt);

    assign stall = id_valid_i &&
                   (((ex_hit_rs || ex_hit_rt) && ex_is_load_q) ||
                    ((mem_hit_rs || mem_hit_rt) && mem_is_load_i) ||
                    (is_branch && (ex_hit_rs || ex_hit_rt)));

    assign stall_o     = stall;
    assign br_taken_o  = id_valid_i && !stall &&
                         (id_jr_i || (id_beq_i && ops_eq) || (id_bne_i && !ops_eq));
    assign br_target_o = id_jr_i ? br_rs : (id_pc_4_i + (id_imm_i << 2));

    // Bubbles only clear the control bits; data fields simply hold.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_wr_en_d   = ex_wr_en_q;
        ex_is_load_d = ex_is_load_q;
        ex_wr_addr_d = ex_wr_addr_q;
        ex_rs_val_d  = ex_rs_val_q;
        ex_rt_val_d  = ex_rt_val_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (!freeze_i) begin
            if (stall || !id_valid_i) begin
                ex_valid_d   = 1'b0;
                ex_wr_en_d   = 1'b0;
                ex_is_load_d = 1'b0;
            end else begin
                ex_valid_d   = 1'b1;
                ex_wr_en_d   = id_wr_en_i;
                ex_is_load_d = id_is_load_i;
                ex_wr_addr_d = id_wr_addr_i;
                ex_rs_val_d  = op_rs;
                ex_rt_val_d  = op_rt;
                ex_imm_d     = id_imm_i;
                ex_ctrl_d    = id_ctrl_i;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !freeze_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_wr_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_wr_addr_q <= '0;
            ex_rs_val_q  <= '0;
            ex_rt_val_q  <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= '0;
            cnt_q        <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_is_load_q <= ex_is_load_d;
            ex_wr_addr_q <= ex_wr_addr_d;
            ex_rs_val_q  <= ex_rs_val_d;
            ex_rt_val_q  <= ex_rt_val_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_wr_en_o     = ex_wr_en_q;
    assign ex_is_load_o   = ex_is_load_q;
    assign ex_wr_addr_o   = ex_wr_addr_q;
    assign ex_rs_val_o    = ex_rs_val_q;
    assign ex_rt_val_o    = ex_rt_val_q;
    assign ex_imm_o       = ex_imm_q;
    assign ex_ctrl_o      = ex_ctrl_q;
    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: ID/EX captures are checked by a scoreboard monitor, hazard
// and branch outputs are checked inline; a CNT_W=2 copy exercises counter saturation.
module tb_id_stage_fwd;

    typedef struct packed {
        logic        wr_en;
        logic        is_load;
        logic [4:0]  wr_addr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [11:0] ctrl;
    } exp_t;

    logic        clk, rst_ni, freeze;
    logic        id_valid, id_use_rs, id_use_rt, id_beq, id_bne, id_jr, id_wr_en, id_is_load;
    logic [31:0] id_pc_4, id_rs_rf, id_rt_rf, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr;
    logic [11:0] id_ctrl;
    logic [31:0] ex_alu_result, mem_wr_data, wb_wr_data;
    logic        mem_wr_en, mem_is_load, wb_wr_en;
    logic [4:0]  mem_wr_addr, wb_wr_addr;

    logic        stall, br_taken, ex_valid, ex_wr_en, ex_is_load;
    logic [31:0] br_target, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_wr_addr;
    logic [11:0] ex_ctrl;
    logic [15:0] stall_cycles;

    logic        s_stall, s_br_taken, s_ex_valid, s_ex_wr_en, s_ex_is_load;
    logic [31:0] s_br_target, s_ex_rs_val, s_ex_rt_val, s_ex_imm;
    logic [4:0]  s_ex_wr_addr;
    logic [11:0] s_ex_ctrl;
    logic [1:0]  s_stall_cycles;

    int   nchk = 0;
    int   nfail = 0;
    int   exp_st = 0;
    logic frz_edge = 1'b0;
    exp_t sb_q[$];

    id_stage_fwd u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .freeze_i(freeze),
        .id_valid_i(id_valid), .id_pc_4_i(id_pc_4),
        .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_rs_rf_i(id_rs_rf), .id_rt_rf_i(id_rt_rf), .id_imm_i(id_imm),
        .id_beq_i(id_beq), .id_bne_i(id_bne), .id_jr_i(id_jr),
        .id_wr_en_i(id_wr_en), .id_is_load_i(id_is_load), .id_wr_addr_i(id_wr_addr),
        .id_ctrl_i(id_ctrl), .ex_alu_result_i(ex_alu_result),
        .mem_wr_en_i(mem_wr_en), .mem_is_load_i(mem_is_load),
        .mem_wr_addr_i(mem_wr_addr), .mem_wr_data_i(mem_wr_data),
        .wb_wr_en_i(wb_wr_en), .wb_wr_addr_i(wb_wr_addr), .wb_wr_data_i(wb_wr_data),
        .stall_o(stall), .br_taken_o(br_taken), .br_target_o(br_target),
        .ex_valid_o(ex_valid), .ex_wr_en_o(ex_wr_en), .ex_is_load_o(ex_is_load),
        .ex_wr_addr_o(ex_wr_addr), .ex_rs_val_o(ex_rs_val), .ex_rt_val_o(ex_rt_val),
        .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .stall_cycles_o(stall_cycles)
    );

    id_stage_fwd #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_ni), .freeze_i(freeze),
        .id_valid_i(id_valid), .id_pc_4_i(id_pc_4),
        .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_rs_rf_i(id_rs_rf), .id_rt_rf_i(id_rt_rf), .id_imm_i(id_imm),
        .id_beq_i(id_beq), .id_bne_i(id_bne), .id_jr_i(id_jr),
        .id_wr_en_i(id_wr_en), .id_is_load_i(id_is_load), .id_wr_addr_i(id_wr_addr),
        .id_ctrl_i(id_ctrl), .ex_alu_result_i(ex_alu_result),
        .mem_wr_en_i(mem_wr_en), .mem_is_load_i(mem_is_load),
        .mem_wr_addr_i(mem_wr_addr), .mem_wr_data_i(mem_wr_data),
        .wb_wr_en_i(wb_wr_en), .wb_wr_addr_i(wb_wr_addr), .wb_wr_data_i(wb_wr_data),
        .stall_o(s_stall), .br_taken_o(s_br_taken), .br_target_o(s_br_target),
        .ex_valid_o(s_ex_valid), .ex_wr_en_o(s_ex_wr_en), .ex_is_load_o(s_ex_is_load),
        .ex_wr_addr_o(s_ex_wr_addr), .ex_rs_val_o(s_ex_rs_val), .ex_rt_val_o(s_ex_rt_val),
        .ex_imm_o(s_ex_imm), .ex_ctrl_o(s_ex_ctrl), .stall_cycles_o(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        freeze = 1'b0;       id_valid = 1'b0;    id_pc_4 = '0;
        id_rs_addr = '0;     id_rt_addr = '0;    id_use_rs = 1'b0;   id_use_rt = 1'b0;
        id_rs_rf = '0;       id_rt_rf = '0;      id_imm = '0;
        id_beq = 1'b0;       id_bne = 1'b0;      id_jr = 1'b0;
        id_wr_en = 1'b0;     id_is_load = 1'b0;  id_wr_addr = '0;    id_ctrl = '0;
        ex_alu_result = '0;  mem_wr_en = 1'b0;   mem_is_load = 1'b0;
        mem_wr_addr = '0;    mem_wr_data = '0;
        wb_wr_en = 1'b0;     wb_wr_addr = '0;    wb_wr_data = '0;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic urs, input logic [31:0] rsrf,
                          input logic [4:0] rt, input logic urt, input logic [31:0] rtrf,
                          input logic we, input logic ld, input logic [4:0] wa,
                          input logic [31:0] imm, input logic [11:0] ctrl);
        id_valid = 1'b1;
        id_rs_addr = rs; id_use_rs = urs; id_rs_rf = rsrf;
        id_rt_addr = rt; id_use_rt = urt; id_rt_rf = rtrf;
        id_wr_en = we;   id_is_load = ld; id_wr_addr = wa;
        id_imm = imm;    id_ctrl = ctrl;
        id_beq = 1'b0;   id_bne = 1'b0;   id_jr = 1'b0;
    endtask

    task automatic br_set(input logic beq, input logic bne, input logic jr,
                          input logic [31:0] pc4);
        id_beq = beq; id_bne = bne; id_jr = jr; id_pc_4 = pc4;
    endtask

    task automatic mem_set(input logic en, input logic ld, input logic [4:0] a,
                           input logic [31:0] d);
        mem_wr_en = en; mem_is_load = ld; mem_wr_addr = a; mem_wr_data = d;
    endtask

    task automatic wb_set(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_wr_en = en; wb_wr_addr = a; wb_wr_data = d;
    endtask

    task automatic expect_ex(input logic we, input logic ld, input logic [4:0] wa,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic [11:0] ctrl);
        exp_t e;
        e.wr_en = we; e.is_load = ld; e.wr_addr = wa;
        e.rs = rs; e.rt = rt; e.imm = imm; e.ctrl = ctrl;
        sb_q.push_back(e);
    endtask

    task automatic chk_stall(input logic exp);
        chk("stall", 32'(stall), 32'(exp));
        chk("sat_stall", 32'(s_stall), 32'(exp));
    endtask

    task automatic chk_br(input logic taken, input logic [31:0] target);
        chk("br_taken", 32'(br_taken), 32'(taken));
        chk("sat_br_taken", 32'(s_br_taken), 32'(taken));
        if (taken) begin
            chk("br_target", br_target, target);
            chk("sat_br_target", s_br_target, target);
        end
    endtask

    task automatic chk_cnt();
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_st));
        chk("sat_stall_cycles", 32'(s_stall_cycles), (exp_st > 3) ? 32'd3 : 32'(exp_st));
    endtask

    task automatic chk_reset();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_wr_en", 32'(ex_wr_en), 32'd0);
        chk("rst_ex_is_load", 32'(ex_is_load), 32'd0);
        chk("rst_ex_wr_addr", 32'(ex_wr_addr), 32'd0);
        chk("rst_ex_rs_val", ex_rs_val, 32'd0);
        chk("rst_ex_rt_val", ex_rt_val, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sat_ex_valid", 32'(s_ex_valid), 32'd0);
        chk("rst_sat_ex_wr_en", 32'(s_ex_wr_en), 32'd0);
        chk("rst_sat_ex_is_load", 32'(s_ex_is_load), 32'd0);
        chk("rst_sat_ex_wr_addr", 32'(s_ex_wr_addr), 32'd0);
        chk("rst_sat_ex_rs_val", s_ex_rs_val, 32'd0);
        chk("rst_sat_ex_rt_val", s_ex_rt_val, 32'd0);
        chk("rst_sat_ex_imm", s_ex_imm, 32'd0);
        chk("rst_sat_ex_ctrl", 32'(s_ex_ctrl), 32'd0);
        chk("rst_sat_stall_cycles", 32'(s_stall_cycles), 32'd0);
    endtask

    // Frozen edges re-present the previous capture, so they are not new outputs.
    always @(posedge clk) frz_edge <= freeze;

    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && ex_valid && !frz_edge) begin
            if (sb_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL sb_underflow: got ex_valid=1 expected no capture at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("ex_wr_en", 32'(ex_wr_en), 32'(e.wr_en));
                chk("ex_is_load", 32'(ex_is_load), 32'(e.is_load));
                chk("ex_wr_addr", 32'(ex_wr_addr), 32'(e.wr_addr));
                chk("ex_rs_val", ex_rs_val, e.rs);
                chk("ex_rt_val", ex_rt_val, e.rt);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
            end
        end
    end

    initial begin
        rst_ni = 1'b1;
        clear_all();
        #2 rst_ni = 1'b0;
        #5 chk_reset();
        @(posedge clk);
        #3 rst_ni = 1'b1;

        // Back-to-back ALU: sub consumes add r3 result from EX
        tick(); id_set(5'd1, 1'b1, 32'd2, 5'd2, 1'b1, 32'd3, 1'b1, 1'b0, 5'd3, 32'd0, 12'h001);
        expect_ex(1'b1, 1'b0, 5'd3, 32'd2, 32'd3, 32'd0, 12'h001);
        #1 chk_stall(1'b0);
        tick(); id_set(5'd3, 1'b1, 32'hBAD, 5'd1, 1'b1, 32'd2, 1'b1, 1'b0, 5'd7, 32'd0, 12'h002);
        ex_alu_result = 32'h0000_0005;
        expect_ex(1'b1, 1'b0, 5'd7, 32'h0000_0005, 32'd2, 32'd0, 12'h002);
        #1 chk_stall(1'b0);
        tick(); clear_all();

        // Load-use: two bubbles, then WB forward
        tick(); id_set(5'd1, 1'b1, 32'h100, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h10, 12'h010);
        expect_ex(1'b1, 1'b1, 5'd4, 32'h100, 32'd0, 32'h10, 12'h010);
        tick(); id_set(5'd4, 1'b1, 32'd0, 5'd2, 1'b1, 32'd7, 1'b1, 1'b0, 5'd5, 32'd0, 12'h020);
        ex_alu_result = 32'h1234;
        #1 chk_stall(1'b1); exp_st++;
        tick(); ex_alu_result = '0; mem_set(1'b1, 1'b1, 5'd4, 32'h5555);
        #1 chk_stall(1'b1); exp_st++;
        chk("bubble_ex_valid", 32'(ex_valid), 32'd0);
        tick(); mem_set(1'b0, 1'b0, 5'd0, 32'd0); wb_set(1'b1, 5'd4, 32'hDEAD_BEEF);
        #1 chk_stall(1'b0); chk_cnt();
        expect_ex(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'd7, 32'd0, 12'h020);
        tick(); clear_all();

        // Branch after ALU producer: one bubble, then MEM forward into compare
        tick(); id_set(5'd1, 1'b1, 32'd3, 5'd2, 1'b1, 32'd4, 1'b1, 1'b0, 5'd5, 32'd0, 12'h030);
        expect_ex(1'b1, 1'b0, 5'd5, 32'd3, 32'd4, 32'd0, 12'h030);
        tick(); id_set(5'd5, 1'b1, 32'd0, 5'd6, 1'b1, 32'd7, 1'b0, 1'b0, 5'd0, 32'd4, 12'h040);
        br_set(1'b1, 1'b0, 1'b0, 32'h100); ex_alu_result = 32'd7;
        #1 chk_stall(1'b1); chk_br(1'b0, 32'd0); exp_st++;
        tick(); ex_alu_result = '0; mem_set(1'b1, 1'b0, 5'd5, 32'd7);
        #1 chk_stall(1'b0); chk_br(1'b1, 32'h110);
        expect_ex(1'b0, 1'b0, 5'd0, 32'd7, 32'd7, 32'd4, 12'h040);
        tick(); clear_all();

        // Branch after load: two bubbles; negative offset wraps
        tick(); id_set(5'd1, 1'b1, 32'h80, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd8, 32'd0, 12'h050);
        expect_ex(1'b1, 1'b1, 5'd8, 32'h80, 32'd0, 32'd0, 12'h050);
        tick(); id_set(5'd8, 1'b1, 32'd3, 5'd0, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0,
                       32'hFFFF_FFFF, 12'h060);
        br_set(1'b1, 1'b0, 1'b0, 32'h200);
        #1 chk_stall(1'b1); chk_br(1'b0, 32'd0); exp_st++;
        tick(); mem_set(1'b1, 1'b1, 5'd8, 32'd9);
        #1 chk_stall(1'b1); exp_st++;
        tick(); mem_set(1'b0, 1'b0, 5'd0, 32'd0); wb_set(1'b1, 5'd8, 32'd0);
        #1 chk_stall(1'b0); chk_br(1'b1, 32'h1FC);
        expect_ex(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 12'h060);
        tick(); clear_all(); #1 chk_cnt();

        // jr redirect and bne not taken
        tick(); id_set(5'd9, 1'b1, 32'h4000, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 12'h070);
        br_set(1'b0, 1'b0, 1'b1, 32'h300);
        #1 chk_stall(1'b0); chk_br(1'b1, 32'h4000);
        expect_ex(1'b0, 1'b0, 5'd0, 32'h4000, 32'd0, 32'd0, 12'h070);
        tick(); id_set(5'd1, 1'b1, 32'h42, 5'd2, 1'b1, 32'h42, 1'b0, 1'b0, 5'd0, 32'd8, 12'h080);
        br_set(1'b0, 1'b1, 1'b0, 32'h300);
        #1 chk_br(1'b0, 32'd0);
        expect_ex(1'b0, 1'b0, 5'd0, 32'h42, 32'h42, 32'd8, 12'h080);
        tick(); clear_all();

        // Forward priority, r0 and unused-source handling
        tick(); id_set(5'd2, 1'b1, 32'h99, 5'd0, 1'b1, 32'h77, 1'b1, 1'b0, 5'd10, 32'd0, 12'h090);
        mem_set(1'b1, 1'b0, 5'd2, 32'h11); wb_set(1'b1, 5'd2, 32'h22);
        #1 chk_stall(1'b0);
        expect_ex(1'b1, 1'b0, 5'd10, 32'h11, 32'd0, 32'd0, 12'h090);
        tick(); id_set(5'd0, 1'b1, 32'h55, 5'd2, 1'b1, 32'h99, 1'b1, 1'b0, 5'd11, 32'd0, 12'h0A0);
        mem_set(1'b1, 1'b0, 5'd0, 32'h11); wb_set(1'b1, 5'd2, 32'h22);
        expect_ex(1'b1, 1'b0, 5'd11, 32'd0, 32'h22, 32'd0, 12'h0A0);
        tick(); id_set(5'd2, 1'b0, 32'h66, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 12'h0B0);
        mem_set(1'b1, 1'b0, 5'd2, 32'h11); wb_set(1'b0, 5'd0, 32'd0);
        expect_ex(1'b0, 1'b0, 5'd0, 32'h66, 32'd0, 32'd0, 12'h0B0);
        tick(); clear_all();

        // Freeze during load-use stall: load held in EX, no count
        tick(); id_set(5'd1, 1'b1, 32'h100, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h10, 12'h0C0);
        expect_ex(1'b1, 1'b1, 5'd4, 32'h100, 32'd0, 32'h10, 12'h0C0);
        tick(); id_set(5'd4, 1'b1, 32'd0, 5'd2, 1'b1, 32'd7, 1'b1, 1'b0, 5'd5, 32'd0, 12'h0D0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            #1 chk_stall(1'b1); chk_cnt();
            chk("frz_ex_valid", 32'(ex_valid), 32'd1);
            chk("frz_ex_is_load", 32'(ex_is_load), 32'd1);
            chk("frz_ex_wr_addr", 32'(ex_wr_addr), 32'd4);
        end
        tick(); freeze = 1'b0;
        #1 chk_stall(1'b1); exp_st++;
        chk("unfrz_ex_valid", 32'(ex_valid), 32'd1);
        tick(); mem_set(1'b1, 1'b1, 5'd4, 32'h5);
        #1 chk_stall(1'b1); exp_st++;
        tick(); mem_set(1'b0, 1'b0, 5'd0, 32'd0); wb_set(1'b1, 5'd4, 32'hDEAD_BEEF);
        #1 chk_stall(1'b0);
        expect_ex(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'd7, 32'd0, 12'h0D0);
        tick(); clear_all(); #1 chk_cnt();

        // Asynchronous reset in the middle of a load-use stall
        tick(); id_set(5'd1, 1'b1, 32'h100, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h10, 12'h0E0);
        expect_ex(1'b1, 1'b1, 5'd4, 32'h100, 32'd0, 32'h10, 12'h0E0);
        tick(); id_set(5'd4, 1'b1, 32'd0, 5'd2, 1'b1, 32'd7, 1'b1, 1'b0, 5'd5, 32'd0, 12'h0F0);
        #1 chk_stall(1'b1);
        @(negedge clk);
        #1 rst_ni = 1'b0;
        #1 chk_reset(); exp_st = 0;
        clear_all();
        @(posedge clk);
        #3 rst_ni = 1'b1;
        tick(); tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode-stage back end with an ID/EX pipeline register. It sits between the register file / control decoder and the EX stage. It selects forwarded operands at decode time, resolves branches and `jr` in ID, and detects load-use and branch-operand hazards. Hazards produce bubbles. It also honours a global pipeline freeze and counts stall cycles.

## Interface
- DATA_W, 32, datapath width
- AW, 5, register address width; address 0 is hardwired zero
- CTRL_W, 12, opaque control bundle carried to EX
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  global hold (memory not ready); ID/EX register and counter keep value
- id_valid  in  1  instruction in ID is real
- id_pc_4  in  DATA_W  PC+4 of ID instruction
- id_rs_addr, id_rt_addr  in  AW  source addresses
- id_use_rs, id_use_rt  in  1  source actually read
- id_rs_rf, id_rt_rf  in  DATA_W  register file read data (no write-through)
- id_imm  in  DATA_W  extended immediate
- id_beq, id_bne, id_jr  in  1  branch/jump-register class
- id_wr_en, id_is_load  in  1  destination write / load
- id_wr_addr  in  AW  destination
- id_ctrl  in  CTRL_W  control bundle
- ex_alu_result  in  DATA_W  combinational ALU output of EX instruction
- mem_wr_en, mem_is_load  in  1; mem_wr_addr  in  AW; mem_wr_data  in  DATA_W  EX/MEM state
- wb_wr_en  in  1; wb_wr_addr  in  AW; wb_wr_data  in  DATA_W  MEM/WB write-back
- stall  out  1  hold PC and IF/ID
- br_taken  out  1  redirect fetch, squash IF
- br_target  out  DATA_W  redirect address
- ex_valid, ex_wr_en, ex_is_load  out  1  registered
- ex_wr_addr  out  AW; ex_rs_val, ex_rt_val, ex_imm  out  DATA_W; ex_ctrl  out  CTRL_W  registered
- stall_cycles  out  CNT_W  saturating stall count

## Operation
- Source match: X matches src S when X_wr_en, X_wr_addr==S, S!=0, and the ID use bit for S is set. EX side also needs ex_valid.
- Operand select, per source, priority high→low:
  - EX (ex_alu_result, only if !ex_is_load)
  - MEM (mem_wr_data, only if !mem_is_load)
  - WB (wb_wr_data)
  - register file
- Address 0 always yields 0.
- Stall conditions (id_valid required), OR of:
  - any source matches EX and ex_is_load
  - any source matches MEM and mem_is_load
  - (id_beq|id_bne|id_jr) and any source matches EX. Branch compare never uses EX forwarding.
- Branch: compare operands come from MEM/WB/RF selection only.
  - br_taken = id_valid & !stall & (id_jr | id_beq&eq | id_bne&!eq)
  - br_target = id_jr ? rs : id_pc_4 + (id_imm<<2), modulo 2^DATA_W
- ID/EX register update, in priority order:
  - freeze: hold all
  - else stall or !id_valid: bubble, i.e. ex_valid=0, ex_wr_en=0, ex_is_load=0, data fields don't-care (implement as hold)
  - else capture selected operands and ID fields
- stall_cycles increments when stall & !freeze. It saturates at 2^CNT_W−1.
- stall and br_taken are combinational; stall is asserted even during freeze.

## Timing
- Reset (rst=0, asynchronous): ex_valid, ex_wr_en, ex_is_load, ex_wr_addr, ex_rs_val, ex_rt_val, ex_imm, ex_ctrl, stall_cycles = 0.
- Latency: ID fields appear on ex_* one edge after capture.
- Load-use: consumer directly behind load → 2 bubbles (load in EX, then MEM), forwarded from WB on third cycle.
- Branch after ALU producer: 1 bubble, then MEM forward.
- Branch after load: 2 bubbles.
- Reset mid-stall: the stall clears immediately because ex_valid=0. The counter is zeroed.
- Freeze and stall together: freeze wins, no bubble, no count.

## Test plan
- Back-to-back ALU: `add r3` then `sub` using r3 → no stall; ex_rs_val equals prior ex_alu_result (e.g. 0x0000_0005).
- Load-use: `lw r4` then `add` using r4 → stall high 2 cycles, 2 bubbles, then ex_rs_val = wb_wr_data 0xDEAD_BEEF; stall_cycles=2.
- Branch: `add r5` (result 7) then `beq r5,r6` with r6=7, imm=4, pc_4=0x100 → 1 stall, then br_taken=1, br_target=0x110.
- Priority: MEM and WB both write r2 (0x11 / 0x22), no EX match → operand 0x11. Same case with r0 → operand 0.
- Freeze: assert freeze during load-use stall for 3 cycles → ex_* unchanged, stall_cycles unchanged. Release → sequence completes as in the load-use case.
- Saturation and reset: CNT_W=2, 5 stalls → stall_cycles=3. Pull rst low mid-cycle → all outputs 0 asynchronously.
